// File: rtl/mmu_result_drain.sv
// Captures finished NxN result tiles from the systolic array and serialises them
// MSB-byte-first onto an 8-bit stream, with an active slot and a pending slot.
module mmu_result_drain #(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [N*N*ACC_W-1:0]   res_data,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned BPE        = ACC_W / 8;
    localparam int unsigned TILE_W     = N * N * ACC_W;
    localparam int unsigned TILE_BYTES = N * N * BPE;
    localparam int unsigned CNT_W      = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TILE_BYTES - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [TILE_W-1:0] active_q, active_d;
    logic [TILE_W-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              out_valid_d;
    logic              out_last_d;
    logic [7:0]        out_data_d;
    logic              res_ready_d;
    logic              busy_d;

    logic              accept_c;
    logic              advance_c;
    logic              at_last_c;

    // Byte idx of a tile: element idx/BPE, MSB byte of each element first.
    function automatic logic [7:0] tile_byte(input logic [TILE_W-1:0] t,
                                             input logic [CNT_W-1:0]  idx);
        int unsigned elem;
        int unsigned sub;
        int unsigned off;
        logic [TILE_W-1:0] sh;
        elem = 32'(idx) / BPE;
        sub  = (BPE - 1) - (32'(idx) % BPE);
        off  = elem * ACC_W + sub * 8;
        sh   = t >> off;
        return sh[7:0];
    endfunction

    assign accept_c  = res_valid && res_ready;
    assign advance_c = (state_q == S_DRAIN) && out_ready;
    assign at_last_c = (cnt_q == LAST_IDX);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    active_d = res_data;
                    cnt_d    = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (advance_c && at_last_c) begin
                    cnt_d = '0;
                    if (pend_full_q) begin
                        active_d    = pend_q;
                        pend_full_d = 1'b0;
                    end else if (accept_c) begin
                        active_d = res_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (advance_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Pending slot is empty whenever res_ready is high.
                    if (accept_c) begin
                        pend_d      = res_data;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        out_valid_d = (state_d == S_DRAIN);
        out_last_d  = out_valid_d && (cnt_d == LAST_IDX);
        out_data_d  = out_valid_d ? tile_byte(active_d, cnt_d) : 8'h00;
        res_ready_d = !pend_full_d;
        busy_d      = out_valid_d || pend_full_d;
    end

    // State, slot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= 8'h00;
            res_ready   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
            out_valid   <= out_valid_d;
            out_last    <= out_last_d;
            out_data    <= out_data_d;
            res_ready   <= res_ready_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_mmu_result_drain.sv
// Bench for mmu_result_drain: directed scenarios plus random traffic, all checked
// against a queue-of-bytes reference model of the two-slot drain.
module tb_mmu_result_drain;

    localparam int unsigned N      = 2;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned TILE_W = N * N * ACC_W;

    logic              clk;
    logic              rst;
    logic              res_valid;
    logic              res_ready;
    logic [TILE_W-1:0] res_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;

    mmu_result_drain #(.N(N), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: bytes still owed ({last, byte}) and number of tiles held (0..2).
    logic [8:0] exp_q[$];
    int         held;
    logic       last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_tile(input logic [TILE_W-1:0] d);
        int unsigned nel;
        nel = N * N;
        for (int k = 0; k < int'(nel); k++) begin
            logic [ACC_W-1:0] el;
            el = d[k*ACC_W +: ACC_W];
            for (int b = int'(ACC_W/8) - 1; b >= 0; b--) begin
                logic [7:0] by;
                logic       lst;
                by  = el[b*8 +: 8];
                lst = (k == int'(nel) - 1) && (b == 0);
                exp_q.push_back({lst, by});
            end
        end
    endtask

    task automatic check_outputs();
        logic       ev;
        logic [7:0] ed;
        logic       el;
        ev = (exp_q.size() > 0);
        ed = ev ? exp_q[0][7:0] : 8'h00;
        el = ev ? exp_q[0][8] : 1'b0;
        check("out_valid", 32'(out_valid), 32'(ev));
        check("out_data",  32'(out_data),  32'(ed));
        check("out_last",  32'(out_last),  32'(el));
        check("res_ready", 32'(res_ready), 32'(held < 2));
        check("busy",      32'(busy),      32'(held > 0));
    endtask

    // One clock: predict handshakes from current inputs, step model, check after edge.
    task automatic cycle();
        logic              acc;
        logic              adv;
        logic [TILE_W-1:0] d;
        logic [8:0]        e;
        acc = !rst && res_valid && (held < 2);
        adv = !rst && (exp_q.size() > 0) && out_ready;
        d   = res_data;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            held = 0;
            acc  = 1'b0;
        end else begin
            if (adv) begin
                e = exp_q.pop_front();
                if (e[8]) held--;
            end
            if (acc) begin
                push_tile(d);
                held++;
            end
        end
        last_acc = acc;
        #1;
        check_outputs();
    endtask

    function automatic logic [TILE_W-1:0] rand_tile();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [7:0]        ref_bytes[8];
        logic [TILE_W-1:0] tile_a;

        clk       = 1'b0;
        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;
        out_ready = 1'b1;
        held      = 0;
        last_acc  = 1'b0;
        ref_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};

        // Reset then idle.
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // Known tile, output bytes against the literal sequence.
        tile_a    = {16'hFF00, 16'h0001, 16'hABCD, 16'h1234};
        res_data  = tile_a;
        res_valid = 1'b1;
        cycle();
        res_valid = 1'b0;
        res_data  = rand_tile();
        for (int i = 0; i < 8; i++) begin
            check("tile_byte", 32'(out_data), 32'(ref_bytes[i]));
            check("tile_last", 32'(out_last), 32'(i == 7));
            cycle();
        end
        check("tile_done_valid", 32'(out_valid), 32'd0);

        // Back-to-back A then B.
        res_data  = rand_tile();
        res_valid = 1'b1;
        cycle();
        res_data  = rand_tile();
        cycle();
        res_valid = 1'b0;
        for (int i = 0; i < 18; i++) cycle();

        // Backpressure after byte 2.
        res_data  = rand_tile();
        res_valid = 1'b1;
        cycle();
        res_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // Full: A active, B pending, C held until accepted.
        res_data  = rand_tile();
        res_valid = 1'b1;
        cycle();
        res_data  = rand_tile();
        cycle();
        res_data  = rand_tile();
        begin
            int waited;
            waited = 0;
            do begin
                cycle();
                waited++;
            end while (!last_acc && waited < 20);
            check("full_c_accepted", 32'(last_acc), 32'd1);
        end
        res_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();

        // Reset during byte 4 of A with B pending.
        res_data  = rand_tile();
        res_valid = 1'b1;
        cycle();
        res_data  = rand_tile();
        cycle();
        res_valid = 1'b0;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        cycle();
        res_data  = rand_tile();
        res_valid = 1'b1;
        cycle();
        res_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            res_valid = ($urandom_range(0, 9) < 4);
            res_data  = rand_tile();
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        res_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
